// File: rtl/hwpe_ctrl_regfile_arbiter_pkg.sv
// Shared types for the HWPE control register-file arbiter.
package hwpe_ctrl_regfile_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAIN
  } rf_arb_state_t;

  typedef enum logic {
    OWN_BUS,
    OWN_ENG
  } rf_arb_owner_t;

endpackage

// File: rtl/hwpe_ctrl_regfile_arbiter_prio.sv
// Two-way read arbiter: fixed bus priority by default, round-robin when
// HWPE_CTRL_REGFILE_ARB_RR_EN is defined.
module hwpe_ctrl_regfile_arb_prio
  import hwpe_ctrl_regfile_arbiter_pkg::*;
(
`ifdef HWPE_CTRL_REGFILE_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic req_bus,
  input  logic req_eng,
  output logic gnt_bus,
  output logic gnt_eng
);

`ifdef HWPE_CTRL_REGFILE_ARB_RR_EN
  rf_arb_owner_t ptr_q;
  logic          contended;

  assign contended = req_bus & req_eng;

  // Pointer names the preferred requester; it moves to the loser of each contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= OWN_BUS;
    end else if (contended) begin
      ptr_q <= (ptr_q == OWN_BUS) ? OWN_ENG : OWN_BUS;
    end
  end

  assign gnt_bus = req_bus & (~req_eng | (ptr_q == OWN_BUS));
`else
  assign gnt_bus = req_bus;
`endif

  assign gnt_eng = req_eng & ~gnt_bus;

endmodule

// File: rtl/hwpe_ctrl_regfile_arbiter.sv
// Shares one 1R1W registered-read regfile between the config bus and the engine.
// Optional round-robin read arbitration via HWPE_CTRL_REGFILE_ARB_RR_EN.
module hwpe_ctrl_regfile_arbiter
  import hwpe_ctrl_regfile_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  bus_req_i,
  output logic                  bus_gnt_o,
  input  logic                  bus_we_i,
  input  logic [ADDR_WIDTH-1:0] bus_add_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  input  logic [NUM_BYTE-1:0]   bus_be_i,
  output logic [DATA_WIDTH-1:0] bus_r_data_o,
  output logic                  bus_r_valid_o,
  input  logic                  eng_req_i,
  output logic                  eng_gnt_o,
  input  logic [ADDR_WIDTH-1:0] eng_add_i,
  output logic [DATA_WIDTH-1:0] eng_r_data_o,
  output logic                  eng_r_valid_o,
  output logic                  rf_clear_o,
  output logic                  rf_re_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [NUM_BYTE-1:0]   rf_wbe_o,
  output logic                  busy_o
);

  rf_arb_state_t         state_q, state_d;
  rf_arb_owner_t         owner_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [DATA_WIDTH-1:0] bus_data_q, eng_data_q;
  logic                  idle, bus_wr, bus_rd, eng_rd, hazard;
  logic                  gnt_bus_rd, gnt_eng_rd;

  always_comb begin
    state_d    = state_q;
    idle       = 1'b0;
    rf_clear_o = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      IDLE:  idle = 1'b1;
      CLEAR: begin
        rf_clear_o = 1'b1;
        busy_o     = 1'b1;
        state_d    = DRAIN;
      end
      DRAIN: begin
        busy_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = CLEAR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An engine read colliding with this cycle's bus write retries once the write has landed.
  assign bus_wr = idle & bus_req_i & bus_we_i;
  assign bus_rd = idle & bus_req_i & ~bus_we_i;
  assign hazard = bus_wr & (eng_add_i == bus_add_i);
  assign eng_rd = idle & eng_req_i & ~hazard;

  hwpe_ctrl_regfile_arb_prio i_prio (
`ifdef HWPE_CTRL_REGFILE_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .req_bus (bus_rd),
    .req_eng (eng_rd),
    .gnt_bus (gnt_bus_rd),
    .gnt_eng (gnt_eng_rd)
  );

  assign bus_gnt_o  = bus_wr | gnt_bus_rd;
  assign eng_gnt_o  = gnt_eng_rd;
  assign rf_we_o    = bus_wr;
  assign rf_waddr_o = bus_add_i;
  assign rf_wdata_o = bus_data_i;
  assign rf_wbe_o   = bus_be_i;
  assign rf_re_o    = gnt_bus_rd | gnt_eng_rd;
  assign rf_raddr_o = gnt_eng_rd ? eng_add_i : (gnt_bus_rd ? bus_add_i : raddr_q);

  assign bus_r_valid_o = valid_q & (owner_q == OWN_BUS);
  assign eng_r_valid_o = valid_q & (owner_q == OWN_ENG);
  assign bus_r_data_o  = bus_r_valid_o ? rf_rdata_i : bus_data_q;
  assign eng_r_data_o  = eng_r_valid_o ? rf_rdata_i : eng_data_q;

  // Response side: owner tag follows the grant by one cycle; each port holds its last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      owner_q    <= OWN_BUS;
      raddr_q    <= '0;
      bus_data_q <= '0;
      eng_data_q <= '0;
    end else begin
      valid_q <= rf_re_o;
      if (rf_re_o) begin
        owner_q <= gnt_eng_rd ? OWN_ENG : OWN_BUS;
        raddr_q <= rf_raddr_o;
      end
      if (bus_r_valid_o) bus_data_q <= rf_rdata_i;
      if (eng_r_valid_o) eng_data_q <= rf_rdata_i;
    end
  end

endmodule
